// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: mode encodings, default field limits and the
// mode-selection rule. Also used by the display and divider blocks.
package stopwatch_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_ADJ   = 2'd2;

    localparam int unsigned DEF_MAX_SEC = 59;
    localparam int unsigned DEF_MAX_MIN = 59;
    localparam int unsigned DEF_CNT_W   = 6;

    // adjust request dominates; otherwise the (already updated) paused flag
    // picks between pause and run
    function automatic logic [1:0] next_mode(input logic adj, input logic paused);
        if (adj)
            return ST_ADJ;
        else if (paused)
            return ST_PAUSE;
        else
            return ST_RUN;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_counter.sv
// mod_counter: modulo-(MAX+1) counter with enable and synchronous clear.
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (q -> 0)
//   en     in   advance by one, wrapping MAX -> 0
//   clr    in   synchronous clear, dominates en
//   q      out  current count
//   at_max out  q is at (or beyond) MAX; next increment wraps to 0
module mod_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_Q = W'(MAX);

    // >= so that an out-of-range value also wraps to 0 on the next increment
    assign at_max = (q >= MAX_Q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= at_max ? '0 : q + W'(1);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode controller and MM:SS time-keeping core.
//   clk, rst     system clock, asynchronous active-high reset
//   tick_1hz     1-cycle enable, advances time in run mode
//   tick_2hz     1-cycle enable, adjust step and blink rate
//   adj          level, requests adjust mode
//   sel          level, adjust target (0 = minutes, 1 = seconds)
//   pause_pulse  1-cycle press, toggles the paused flag
//   clr          1-cycle press, zeroes both time fields
//   minutes      current minutes
//   seconds      current seconds
//   mode         current mode (ST_RUN / ST_PAUSE / ST_ADJ)
//   blink        blank phase for the field being adjusted
//   rollover     1-cycle pulse when MAX_MIN:MAX_SEC wraps to 00:00 in run
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_SEC = DEF_MAX_SEC,
    parameter int unsigned MAX_MIN = DEF_MAX_MIN,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_pulse,
    input  logic             clr,
    output logic [CNT_W-1:0] minutes,
    output logic [CNT_W-1:0] seconds,
    output logic [1:0]       mode,
    output logic             blink,
    output logic             rollover
);

    logic       paused;
    logic       paused_next;
    logic [1:0] mode_next;
    logic       sec_at_max;
    logic       min_at_max;
    logic       sec_en;
    logic       min_en;
    logic       run_tick;
    logic       adj_tick;

    // increment decisions use the mode held at the start of the cycle
    assign run_tick = (mode == ST_RUN) && tick_1hz;
    assign adj_tick = (mode == ST_ADJ) && tick_2hz;

    // run: seconds every tick, minutes carry from seconds wrap
    // adjust: only the selected field steps, no carry
    assign sec_en = run_tick || (adj_tick && sel);
    assign min_en = (run_tick && sec_at_max) || (adj_tick && !sel);

    // pause presses made during adjust land in the flag and show on exit
    assign paused_next = paused ^ pause_pulse;
    assign mode_next   = next_mode(adj, paused_next);

    mod_counter #(.MAX(MAX_SEC), .W(CNT_W)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .en     (sec_en),
        .clr    (clr),
        .q      (seconds),
        .at_max (sec_at_max)
    );

    mod_counter #(.MAX(MAX_MIN), .W(CNT_W)) u_min (
        .clk    (clk),
        .rst    (rst),
        .en     (min_en),
        .clr    (clr),
        .q      (minutes),
        .at_max (min_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= ST_RUN;
            paused   <= 1'b0;
            blink    <= 1'b0;
            rollover <= 1'b0;
        end else begin
            mode     <= mode_next;
            paused   <= paused_next;
            rollover <= run_tick && sec_at_max && min_at_max && !clr;
            // blink is forced low as soon as the next mode leaves adjust
            if (mode_next != ST_ADJ)
                blink <= 1'b0;
            else if (adj_tick)
                blink <= ~blink;
        end
    end

endmodule
